// File: rtl/mnist_pkg.sv
// Shared definitions for the MNIST frame sequencer: FSM state encoding and
// default frame/class geometry.
package mnist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STREAM,
        ST_WAIT,
        ST_ARGMAX,
        ST_DONE
    } state_e;

    localparam int DEFAULT_N       = 8;
    localparam int IMG_PIXELS      = 784;
    localparam int NUM_CLASS       = 10;
    localparam int CLS_W           = $clog2(NUM_CLASS);
    localparam int DEFAULT_TIMEOUT = 4096;

endpackage

// File: rtl/mnist_argmax_seq.sv
// Sequential signed argmax: captures a score vector, then performs one
// compare per enabled cycle; ties resolve to the lowest index.
module mnist_argmax_seq #(
    parameter int N         = mnist_pkg::DEFAULT_N,
    parameter int NUM_CLASS = mnist_pkg::NUM_CLASS,
    parameter int CLS_W     = mnist_pkg::CLS_W
) (
    input  logic                   clk,
    input  logic                   load,
    input  logic [NUM_CLASS*N-1:0] scores,
    input  logic                   start,
    output logic                   done,
    output logic [CLS_W-1:0]       idx,
    output logic signed [N-1:0]    max_val
);
    import mnist_pkg::*;

    localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(NUM_CLASS - 1);

    logic signed [N-1:0] score_q [NUM_CLASS];
    logic signed [N-1:0] score_d [NUM_CLASS];
    logic signed [N-1:0] max_q, max_d, cand;
    logic [CLS_W-1:0]    idx_q, idx_d, iter_q, iter_d;
    logic                take;

    // idx/max_val already include this cycle's compare so the last step is
    // visible to the caller in the same cycle that done is raised.
    always_comb begin
        cand    = score_q[iter_q];
        take    = start && (cand > max_q);
        done    = start && (iter_q == LAST_IDX);
        idx     = take ? iter_q : idx_q;
        max_val = take ? cand : max_q;

        score_d = score_q;
        max_d   = max_q;
        idx_d   = idx_q;
        iter_d  = iter_q;
        if (load) begin
            for (int k = 0; k < NUM_CLASS; k++) begin
                score_d[k] = scores[k*N +: N];
            end
            max_d  = scores[N-1:0];
            idx_d  = '0;
            iter_d = CLS_W'(1);
        end else if (start) begin
            max_d  = max_val;
            idx_d  = idx;
            iter_d = iter_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        score_q <= score_d;
        max_q   <= max_d;
        idx_q   <= idx_d;
        iter_q  <= iter_d;
    end

endmodule

// File: rtl/mnist_frame_ctrl.sv
// Per-image sequencer: streams one frame into the conv pipeline, waits for
// the class scores, runs the argmax and reports class/score or a timeout.
module mnist_frame_ctrl #(
    parameter int N          = mnist_pkg::DEFAULT_N,
    parameter int IMG_PIXELS = mnist_pkg::IMG_PIXELS,
    parameter int NUM_CLASS  = mnist_pkg::NUM_CLASS,
    parameter int CLS_W      = mnist_pkg::CLS_W,
    parameter int TIMEOUT    = mnist_pkg::DEFAULT_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   weight_load_done,
    input  logic                   start,
    output logic                   busy,
    input  logic                   pix_vld,
    output logic                   pix_rdy,
    input  logic [N-1:0]           pix_din,
    output logic                   net_ce,
    output logic                   net_input_vld,
    output logic [N-1:0]           net_input_din,
    input  logic [NUM_CLASS*N-1:0] net_dout,
    input  logic                   net_dout_vld,
    input  logic                   net_dout_end,
    output logic                   result_vld,
    output logic [CLS_W-1:0]       result_class,
    output logic signed [N-1:0]    result_score,
    output logic                   timeout_err
);
    import mnist_pkg::*;

    localparam int PIX_W = $clog2(IMG_PIXELS);
    localparam int TO_W  = $clog2(TIMEOUT);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(IMG_PIXELS - 1);
    localparam logic [TO_W-1:0]  LAST_TO  = TO_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [CLS_W-1:0]    result_class_q, result_class_d;
    logic signed [N-1:0] result_score_q, result_score_d;
    logic                result_vld_q, result_vld_d;
    logic                timeout_err_q, timeout_err_d;

    logic                am_load, am_start, am_done;
    logic [CLS_W-1:0]    am_idx;
    logic signed [N-1:0] am_max;

    mnist_argmax_seq #(
        .N         (N),
        .NUM_CLASS (NUM_CLASS),
        .CLS_W     (CLS_W)
    ) u_argmax (
        .clk     (clk),
        .load    (am_load),
        .scores  (net_dout),
        .start   (am_start),
        .done    (am_done),
        .idx     (am_idx),
        .max_val (am_max)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            pix_cnt_q      <= '0;
            to_cnt_q       <= '0;
            result_class_q <= '0;
            result_score_q <= '0;
            result_vld_q   <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            pix_cnt_q      <= pix_cnt_d;
            to_cnt_q       <= to_cnt_d;
            result_class_q <= result_class_d;
            result_score_q <= result_score_d;
            result_vld_q   <= result_vld_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pix_cnt_d      = pix_cnt_q;
        to_cnt_d       = to_cnt_q;
        result_class_d = result_class_q;
        result_score_d = result_score_q;
        timeout_err_d  = 1'b0;
        am_load        = 1'b0;
        am_start       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pix_cnt_d = '0;
                if (start && weight_load_done) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (pix_vld) begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                    if (pix_cnt_q == LAST_PIX) begin
                        state_d  = ST_WAIT;
                        to_cnt_d = '0;
                    end
                end
            end
            ST_WAIT: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (net_dout_vld) begin
                    am_load = 1'b1;
                    state_d = ST_ARGMAX;
                end else if (to_cnt_q == LAST_TO) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_ARGMAX: begin
                am_start = 1'b1;
                if (am_done) begin
                    result_class_d = am_idx;
                    result_score_d = am_max;
                    state_d        = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        result_vld_d = (state_d == ST_DONE);
    end

    // Pipeline runs only while pixels are flowing or scores are pending.
    always_comb begin
        busy          = (state_q != ST_IDLE);
        pix_rdy       = (state_q == ST_STREAM);
        net_ce        = (state_q == ST_STREAM) || (state_q == ST_WAIT);
        net_input_vld = (state_q == ST_STREAM) && pix_vld;
        net_input_din = pix_din;
    end

    assign result_vld   = result_vld_q;
    assign result_class = result_class_q;
    assign result_score = result_score_q;
    assign timeout_err  = timeout_err_q;

    a_end_with_vld: assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_WAIT && net_dout_end) |-> net_dout_vld);

endmodule

// File: tb/tb_mnist_frame_ctrl.sv
// Directed bench for mnist_frame_ctrl with a stub network returning fixed
// score vectors.
module tb_mnist_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst, weight_load_done, start, pix_vld;
    logic [7:0]  pix_din;
    logic        busy, pix_rdy, net_ce, net_input_vld;
    logic [7:0]  net_input_din;
    logic [79:0] net_dout;
    logic        net_dout_vld, net_dout_end;
    logic        result_vld, timeout_err;
    logic [3:0]  result_class;
    logic [7:0]  result_score;

    int checks = 0;
    int errors = 0;
    int beat_cnt = 0;
    int res_cnt = 0;

    mnist_frame_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .weight_load_done (weight_load_done),
        .start            (start),
        .busy             (busy),
        .pix_vld          (pix_vld),
        .pix_rdy          (pix_rdy),
        .pix_din          (pix_din),
        .net_ce           (net_ce),
        .net_input_vld    (net_input_vld),
        .net_input_din    (net_input_din),
        .net_dout         (net_dout),
        .net_dout_vld     (net_dout_vld),
        .net_dout_end     (net_dout_end),
        .result_vld       (result_vld),
        .result_class     (result_class),
        .result_score     (result_score),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (net_input_vld) beat_cnt <= beat_cnt + 1;
        if (result_vld)    res_cnt  <= res_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
    endtask

    task automatic stream(input int npix, input bit gaps, input string tag);
        int  sent = 0;
        int  cyc = 0;
        int  ce_bad = 0;
        int  b0 = beat_cnt;
        bit  v;
        while (sent < npix && cyc < 4000) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_vld = v;
            pix_din = 8'(sent + 17);
            #1;
            if (sent == 3 && v) begin
                chk({tag, "_din_pass"}, net_input_din, 8'(sent + 17));
                chk({tag, "_vld_pass"}, net_input_vld, 1);
            end
            if (!net_ce) ce_bad++;
            if (v && pix_rdy) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        pix_vld = 1'b0;
        chk({tag, "_pix_sent"}, sent, npix);
        chk({tag, "_beats"}, beat_cnt - b0, npix);
        chk({tag, "_ce_stream"}, ce_bad, 0);
    endtask

    task automatic finish_frame(input logic [79:0] sc, input logic [3:0] ecls,
                                input logic [7:0] escore, input string tag);
        int n = 0;
        int r0 = res_cnt;
        chk({tag, "_rdy_wait"}, pix_rdy, 0);
        repeat (3) tick();
        chk({tag, "_ce_wait"}, net_ce, 1);
        net_dout     = sc;
        net_dout_vld = 1'b1;
        net_dout_end = 1'b1;
        tick();
        net_dout_vld = 1'b0;
        net_dout_end = 1'b0;
        net_dout     = '0;
        chk({tag, "_ce_argmax"}, net_ce, 0);
        while (!result_vld && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 9);
        chk({tag, "_class"}, result_class, ecls);
        chk({tag, "_score"}, result_score, escore);
        tick();
        chk({tag, "_vld_pulse"}, result_vld, 0);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_class_hold"}, result_class, ecls);
        chk({tag, "_one_result"}, res_cnt - r0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [79:0] sc;
        int n;
        int r0;

        rst = 1'b1; weight_load_done = 1'b0; start = 1'b0; pix_vld = 1'b0;
        pix_din = '0; net_dout = '0; net_dout_vld = 1'b0; net_dout_end = 1'b0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_pix_rdy", pix_rdy, 0);
        chk("rst_net_ce", net_ce, 0);
        chk("rst_result_vld", result_vld, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_class", result_class, 0);
        chk("rst_score", result_score, 0);
        rst = 1'b0;
        tick();

        // 1: start without weights is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_nowt_busy", busy, 0);
        chk("t1_nowt_rdy", pix_rdy, 0);
        tick();
        chk("t1_nowt_busy2", busy, 0);
        weight_load_done = 1'b1;
        start_frame("t1");
        chk("t1_rdy", pix_rdy, 1);

        // 2: class 3 wins with +90, others -5
        stream(784, 1'b0, "t2");
        for (int k = 0; k < 10; k++) sc[k*8 +: 8] = (k == 3) ? 8'h5A : 8'hFB;
        finish_frame(sc, 4'd3, 8'h5A, "t2");

        // 3a: tie between 2 and 7, lowest index wins
        start_frame("t3a");
        stream(784, 1'b0, "t3a");
        for (int k = 0; k < 10; k++) sc[k*8 +: 8] = 8'h05;
        sc[0*8 +: 8] = 8'h80;
        sc[2*8 +: 8] = 8'h28;
        sc[7*8 +: 8] = 8'h28;
        sc[5*8 +: 8] = 8'hF0;
        finish_frame(sc, 4'd2, 8'h28, "t3a");

        // 3b: all minimum scores -> class 0
        start_frame("t3b");
        stream(784, 1'b0, "t3b");
        for (int k = 0; k < 10; k++) sc[k*8 +: 8] = 8'h80;
        finish_frame(sc, 4'd0, 8'h80, "t3b");

        // 4: gappy source, weights dropped mid-frame, winner at last index
        start_frame("t4");
        weight_load_done = 1'b0;
        stream(784, 1'b1, "t4");
        for (int k = 0; k < 10; k++) sc[k*8 +: 8] = 8'h7E;
        sc[9*8 +: 8] = 8'h7F;
        finish_frame(sc, 4'd9, 8'h7F, "t4");
        weight_load_done = 1'b1;

        // Scores arriving while idle are ignored
        net_dout_vld = 1'b1;
        tick();
        net_dout_vld = 1'b0;
        chk("idle_vld_busy", busy, 0);
        tick();
        chk("idle_vld_result", result_vld, 0);

        // 5: network never answers
        start_frame("t5");
        stream(784, 1'b0, "t5");
        r0 = res_cnt;
        n = 0;
        while (!timeout_err && n < 5000) begin
            tick();
            n++;
        end
        chk("t5_timeout_lat", n, 4096);
        chk("t5_busy", busy, 0);
        chk("t5_no_result", result_vld, 0);
        tick();
        chk("t5_timeout_pulse", timeout_err, 0);
        chk("t5_no_result_cnt", res_cnt - r0, 0);
        start_frame("t5b");
        stream(784, 1'b0, "t5b");
        for (int k = 0; k < 10; k++) sc[k*8 +: 8] = 8'(k);
        sc[5*8 +: 8] = 8'h33;
        finish_frame(sc, 4'd5, 8'h33, "t5b");

        // 6: reset mid-frame, then a clean frame with a start while busy
        start_frame("t6");
        stream(400, 1'b0, "t6_part");
        r0 = res_cnt;
        rst = 1'b1;
        tick();
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rdy", pix_rdy, 0);
        chk("t6_rst_ce", net_ce, 0);
        chk("t6_rst_result_vld", result_vld, 0);
        chk("t6_rst_timeout", timeout_err, 0);
        chk("t6_rst_class", result_class, 0);
        chk("t6_rst_score", result_score, 0);
        rst = 1'b0;
        tick();
        chk("t6_rst_no_result", res_cnt - r0, 0);
        start_frame("t6b");
        stream(784, 1'b0, "t6b");
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) sc[k*8 +: 8] = 8'hC0;
        sc[6*8 +: 8] = 8'h01;
        finish_frame(sc, 4'd6, 8'h01, "t6b");
        tick(); tick();
        chk("t6_start_not_queued", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
